// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline memory stage: store widths,
// load extension ops, MemtoReg select codes, plus the alignment rule
// that both the store and load paths use.
package mips_pkg;

   // Store width carried on BEopM
   typedef enum logic [1:0] {
      BE_WORD = 2'b00,
      BE_HALF = 2'b01,
      BE_BYTE = 2'b10,
      BE_RSVD = 2'b11
   } be_op_e;

   // Load extension carried on LoadopM; codes above LD_H are reserved
   typedef enum logic [2:0] {
      LD_W  = 3'b000,
      LD_BU = 3'b001,
      LD_B  = 3'b010,
      LD_HU = 3'b011,
      LD_H  = 3'b100
   } load_op_e;

   // Access width derived from either opcode; ACC_NONE marks reserved codes
   typedef enum logic [1:0] {
      ACC_WORD,
      ACC_HALF,
      ACC_BYTE,
      ACC_NONE
   } acc_width_e;

   // MemtoRegM value that selects the memory result (load active)
   localparam logic [1:0] MTR_MEM = 2'b01;

   // Words need lane 0, halves need an even lane, bytes are always fine
   function automatic logic is_misaligned(input acc_width_e width, input logic [1:0] lane);
      logic mis;
      mis = 1'b0;
      case (width)
         ACC_WORD: mis = (lane != 2'b00);
         ACC_HALF: mis = lane[0];
         default:  mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_ext.sv
// Lane select plus sign/zero extension of a fetched memory word.
// Kept standalone so the W stage can reuse it if loads move there.
module load_ext
   import mips_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  loadop_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and the addressed halfword out of the word
   always_comb begin
      byte_sel = word_i[7:0];
      case (lane_i)
         2'b00: byte_sel = word_i[7:0];
         2'b01: byte_sel = word_i[15:8];
         2'b10: byte_sel = word_i[23:16];
         2'b11: byte_sel = word_i[31:24];
         default: byte_sel = word_i[7:0];
      endcase
      half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
   end

   // Extend the selected lane; reserved ops hand back the raw word
   always_comb begin
      data_o = word_i;
      case (loadop_i)
         LD_W:    data_o = word_i;
         LD_BU:   data_o = {24'h000000, byte_sel};
         LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         LD_HU:   data_o = {16'h0000, half_sel};
         LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/dm_stage_unit.sv
// M-stage data memory: word/half/byte stores into a word array, zero-latency
// extended loads, sticky misalignment flag and a committed-store counter.
// Optional store trace printing is enabled with the DM_WRITE_LOG_EN macro.
module dm_stage_unit
   import mips_pkg::*;
#(
   parameter int          DEPTH_W   = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic [1:0]  MemtoRegM,
   input  logic [1:0]  BEopM,
   input  logic [2:0]  LoadopM,
   input  logic [31:0] ALUoutM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PC_4M,
   output logic [31:0] ReadDataM,
   output logic        AlignErr,
   output logic [15:0] StoreCnt
);

   localparam int WORDS = 1 << DEPTH_W;

   logic [31:0]        mem_q [WORDS];
   logic               align_err_q, align_err_d;
   logic [15:0]        store_cnt_q, store_cnt_d;

   logic [31:0]        off;
   logic               in_range;
   logic [DEPTH_W-1:0] idx;
   logic [1:0]         lane;
   logic [31:0]        cur_word;

   acc_width_e         st_width;
   acc_width_e         ld_width;
   logic               st_mis;
   logic               ld_mis;
   logic               st_commit;
   logic               load_active;
   logic [31:0]        merged_word;
   logic [31:0]        ext_data;

   // Decode the byte address relative to the array base
   always_comb begin
      off      = ALUoutM - BASE_ADDR;
      in_range = ((off >> (DEPTH_W + 2)) == 32'd0);
      idx      = off[DEPTH_W+1:2];
      lane     = off[1:0];
      cur_word = mem_q[idx];
   end

   // Classify store and load widths, then check their alignment
   always_comb begin
      st_width = ACC_NONE;
      case (BEopM)
         BE_WORD: st_width = ACC_WORD;
         BE_HALF: st_width = ACC_HALF;
         BE_BYTE: st_width = ACC_BYTE;
         default: st_width = ACC_NONE;
      endcase
      ld_width = ACC_NONE;
      case (LoadopM)
         LD_W:          ld_width = ACC_WORD;
         LD_BU, LD_B:   ld_width = ACC_BYTE;
         LD_HU, LD_H:   ld_width = ACC_HALF;
         default:       ld_width = ACC_NONE;
      endcase
      st_mis      = is_misaligned(st_width, lane);
      ld_mis      = is_misaligned(ld_width, lane);
      load_active = (MemtoRegM == MTR_MEM);
      st_commit   = MemWriteM && in_range && !st_mis && (st_width != ACC_NONE);
   end

   // Merge the store data into the current word; untouched bytes keep their value
   always_comb begin
      merged_word = cur_word;
      case (st_width)
         ACC_WORD: merged_word = WriteDataM;
         ACC_HALF: begin
            if (lane[1]) merged_word[31:16] = WriteDataM[15:0];
            else         merged_word[15:0]  = WriteDataM[15:0];
         end
         ACC_BYTE: begin
            case (lane)
               2'b00: merged_word[7:0]   = WriteDataM[7:0];
               2'b01: merged_word[15:8]  = WriteDataM[7:0];
               2'b10: merged_word[23:16] = WriteDataM[7:0];
               2'b11: merged_word[31:24] = WriteDataM[7:0];
               default: merged_word = cur_word;
            endcase
         end
         default: merged_word = cur_word;
      endcase
   end

   load_ext u_load_ext (
      .word_i   (cur_word),
      .lane_i   (lane),
      .loadop_i (LoadopM),
      .data_o   (ext_data)
   );

   // Load result: out-of-range and misaligned active loads read as zero
   always_comb begin
      ReadDataM = ext_data;
      if (!in_range) begin
         ReadDataM = 32'h0000_0000;
      end else if (load_active && ld_mis) begin
         ReadDataM = 32'h0000_0000;
      end
   end

   // Sticky error and store count next-state
   always_comb begin
      align_err_d = align_err_q | (MemWriteM & st_mis) | (load_active & ld_mis);
      store_cnt_d = store_cnt_q;
      if (st_commit) begin
         store_cnt_d = store_cnt_q + 16'd1;
      end
   end

   // Word array: cleared by reset, written only on a committed store
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) begin
            mem_q[i] <= 32'h0000_0000;
         end
      end else if (st_commit) begin
         mem_q[idx] <= merged_word;
`ifdef DM_WRITE_LOG_EN
         $display("%d@%h: *%h <= %h", $time, PC_4M - 32'd4,
                  {ALUoutM[31:2], 2'b00}, merged_word);
`endif
      end
   end

   // Status registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         align_err_q <= 1'b0;
         store_cnt_q <= 16'h0000;
      end else begin
         align_err_q <= align_err_d;
         store_cnt_q <= store_cnt_d;
      end
   end

`ifndef DM_WRITE_LOG_EN
   // PC is only consumed by the store trace
   logic unused_pc;
   assign unused_pc = ^PC_4M;
`endif

   assign AlignErr = align_err_q;
   assign StoreCnt = store_cnt_q;

endmodule

// File: tb/tb_dm_stage_unit.sv
// Directed bench for dm_stage_unit: stores of each width, extended loads,
// misalignment, out-of-range, read-during-write and asynchronous reset.
module tb_dm_stage_unit;

   logic        clk;
   logic        reset;
   logic        MemWriteM;
   logic [1:0]  MemtoRegM;
   logic [1:0]  BEopM;
   logic [2:0]  LoadopM;
   logic [31:0] ALUoutM;
   logic [31:0] WriteDataM;
   logic [31:0] PC_4M;
   logic [31:0] ReadDataM;
   logic        AlignErr;
   logic [15:0] StoreCnt;

   int nAsserts = 0;
   int nFails   = 0;

   dm_stage_unit dut (
      .clk        (clk),
      .reset      (reset),
      .MemWriteM  (MemWriteM),
      .MemtoRegM  (MemtoRegM),
      .BEopM      (BEopM),
      .LoadopM    (LoadopM),
      .ALUoutM    (ALUoutM),
      .WriteDataM (WriteDataM),
      .PC_4M      (PC_4M),
      .ReadDataM  (ReadDataM),
      .AlignErr   (AlignErr),
      .StoreCnt   (StoreCnt)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one set of M-stage inputs and let the combinational paths settle
   task automatic applyStimulus(input logic we, input logic [1:0] mtr, input logic [1:0] beop,
                                input logic [2:0] ldop, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] pc4);
      MemWriteM  = we;
      MemtoRegM  = mtr;
      BEopM      = beop;
      LoadopM    = ldop;
      ALUoutM    = addr;
      WriteDataM = wdata;
      PC_4M      = pc4;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and sample one unit later
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Load helper: idle store side, MemtoRegM selecting memory
   task automatic doLoad(input logic [2:0] ldop, input logic [31:0] addr);
      applyStimulus(1'b0, 2'b01, 2'b00, ldop, addr, 32'h0, 32'h0);
   endtask

   // Store helper: commits on the next rising edge
   task automatic doStore(input logic [1:0] beop, input logic [31:0] addr, input logic [31:0] wdata);
      applyStimulus(1'b1, 2'b00, beop, 3'b000, addr, wdata, 32'h0000_1004);
      stepClock();
   endtask

   // Linear directed sequence
   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 2'b01, 2'b00, 3'b000, 32'h10, 32'h0, 32'h0);
      checkOutput("reset_read",     ReadDataM, 32'h0);
      checkOutput("reset_alignerr", {31'h0, AlignErr}, 32'h0);
      checkOutput("reset_storecnt", {16'h0, StoreCnt}, 32'h0);
      stepClock();
      reset = 1'b0;
      #1;

      // sw then lw of the same word
      doStore(2'b00, 32'h10, 32'hDEAD_BEEF);
      doLoad(3'b000, 32'h10);
      checkOutput("sw_lw_data",     ReadDataM, 32'hDEAD_BEEF);
      checkOutput("sw_lw_cnt",      {16'h0, StoreCnt}, 32'd1);
      checkOutput("sw_lw_alignerr", {31'h0, AlignErr}, 32'h0);

      // byte store into lane 1 and byte loads
      doStore(2'b00, 32'h20, 32'h1122_3344);
      doStore(2'b10, 32'h21, 32'h0000_00AB);
      doLoad(3'b000, 32'h20);
      checkOutput("sb_word",   ReadDataM, 32'h1122_AB44);
      doLoad(3'b010, 32'h21);
      checkOutput("lb_neg",    ReadDataM, 32'hFFFF_FFAB);
      doLoad(3'b001, 32'h21);
      checkOutput("lbu",       ReadDataM, 32'h0000_00AB);
      doLoad(3'b010, 32'h20);
      checkOutput("lb_pos",    ReadDataM, 32'h0000_0044);
      doLoad(3'b010, 32'h23);
      checkOutput("lb_lane3",  ReadDataM, 32'h0000_0011);
      doLoad(3'b101, 32'h21);
      checkOutput("ld_rsvd_raw", ReadDataM, 32'h1122_AB44);

      // halfword store into the upper half and half loads
      doStore(2'b01, 32'h32, 32'h0000_8001);
      doLoad(3'b000, 32'h30);
      checkOutput("sh_word", ReadDataM, 32'h8001_0000);
      doLoad(3'b100, 32'h32);
      checkOutput("lh_neg",  ReadDataM, 32'hFFFF_8001);
      doLoad(3'b011, 32'h32);
      checkOutput("lhu",     ReadDataM, 32'h0000_8001);
      checkOutput("cnt_after_sh", {16'h0, StoreCnt}, 32'd4);

      // reserved store width is suppressed
      doStore(2'b11, 32'h30, 32'hFFFF_FFFF);
      doLoad(3'b000, 32'h30);
      checkOutput("be_rsvd_word", ReadDataM, 32'h8001_0000);
      checkOutput("be_rsvd_cnt",  {16'h0, StoreCnt}, 32'd4);

      // out-of-range store: no change, no count, no error
      doStore(2'b00, 32'h0000_1000, 32'h1234_5678);
      doLoad(3'b000, 32'h0000_1000);
      checkOutput("oor_read",     ReadDataM, 32'h0);
      checkOutput("oor_cnt",      {16'h0, StoreCnt}, 32'd4);
      checkOutput("oor_alignerr", {31'h0, AlignErr}, 32'h0);
      doLoad(3'b000, 32'h0);
      checkOutput("oor_no_alias", ReadDataM, 32'h0);

      // misaligned word store
      doStore(2'b00, 32'h40, 32'h0000_0055);
      applyStimulus(1'b1, 2'b00, 2'b00, 3'b000, 32'h41, 32'h0000_0099, 32'h0);
      checkOutput("mis_sw_pre_err", {31'h0, AlignErr}, 32'h0);
      stepClock();
      doLoad(3'b000, 32'h40);
      checkOutput("mis_sw_word", ReadDataM, 32'h0000_0055);
      checkOutput("mis_sw_err",  {31'h0, AlignErr}, 32'h1);
      checkOutput("mis_sw_cnt",  {16'h0, StoreCnt}, 32'd5);

      // misaligned half load reads zero; aligned neighbour still reads data
      doLoad(3'b100, 32'h43);
      checkOutput("mis_lh_zero", ReadDataM, 32'h0);
      doLoad(3'b011, 32'h40);
      checkOutput("lhu_lower", ReadDataM, 32'h0000_0055);

      // read during write: old data this cycle, new data next cycle
      applyStimulus(1'b1, 2'b01, 2'b00, 3'b000, 32'h10, 32'hCAFE_F00D, 32'h0000_3004);
      checkOutput("rdw_old", ReadDataM, 32'hDEAD_BEEF);
      stepClock();
      doLoad(3'b000, 32'h10);
      checkOutput("rdw_new", ReadDataM, 32'hCAFE_F00D);
      checkOutput("rdw_cnt", {16'h0, StoreCnt}, 32'd6);
      checkOutput("err_sticky", {31'h0, AlignErr}, 32'h1);

      // asynchronous reset mid-cycle
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_err",  {31'h0, AlignErr}, 32'h0);
      checkOutput("async_rst_cnt",  {16'h0, StoreCnt}, 32'd0);
      checkOutput("async_rst_read", ReadDataM, 32'h0);
      doLoad(3'b000, 32'h20);
      checkOutput("async_rst_word20", ReadDataM, 32'h0);

      // store in flight while reset is high is lost
      applyStimulus(1'b1, 2'b00, 2'b00, 3'b000, 32'h50, 32'h7777_7777, 32'h0);
      stepClock();
      reset = 1'b0;
      doLoad(3'b000, 32'h50);
      checkOutput("rst_store_lost", ReadDataM, 32'h0);
      checkOutput("rst_store_cnt",  {16'h0, StoreCnt}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
